// File: rtl/demorgan_sweep.sv
// ============================================================================
// Module   : demorgan_sweep
// Purpose  : Exhaustive stimulus/response checker for the DeMorgan gate block.
//            Drives every (A,B) operand pair, holds each for SETTLE cycles,
//            then compares the six gate outputs against their golden values.
//            It keeps a saturating error count and captures the first failure.
// Ports    : clk, reset         - single clock, synchronous active-high reset
//            start              - launch a sweep (ignored while busy)
//            A, B               - registered operands to the gate block
//            nA .. nAornB       - gate-block outputs under check
//            busy, done, pass   - sweep status / result
//            err_count          - failing vectors, saturating at 2^ERRW-1
//            fail_A, fail_B     - operands of the first failing vector
//            fail_mask          - [0]nA [1]nB [2]nAandnB [3]AorB [4]npAorB
//                                 [5]nAornB mismatch bits of first failure
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demorgan_sweep #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] nA,
  input  logic [WIDTH-1:0] nB,
  input  logic [WIDTH-1:0] nAandnB,
  input  logic [WIDTH-1:0] AorB,
  input  logic [WIDTH-1:0] npAorB,
  input  logic [WIDTH-1:0] nAornB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] fail_A,
  output logic [WIDTH-1:0] fail_B,
  output logic [5:0]       fail_mask
);

  localparam int c_VW = 2 * WIDTH;
  // Counter needs at least one bit even when SETTLE == 1.
  localparam int c_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(SETTLE - 1);
  localparam logic [c_VW-1:0] c_V_LAST   = {c_VW{1'b1}};
  localparam logic [ERRW-1:0] c_ERR_MAX  = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [c_VW-1:0]  v_q, v_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [5:0]       fail_mask_q, fail_mask_d;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [5:0]       w_mask;

  // A is the fast-moving half of the vector index.
  assign w_a = v_q[WIDTH-1:0];
  assign w_b = v_q[c_VW-1:WIDTH];

  // One mismatch bit per checked signal, set if any bit differs from golden.
  always_comb begin
    w_mask    = '0;
    w_mask[0] = |(nA      ^ ~w_a);
    w_mask[1] = |(nB      ^ ~w_b);
    w_mask[2] = |(nAandnB ^ (~w_a & ~w_b));
    w_mask[3] = |(AorB    ^ (w_a | w_b));
    w_mask[4] = |(npAorB  ^ ~(w_a | w_b));
    w_mask[5] = |(nAornB  ^ (~w_a | ~w_b));
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          v_d         = '0;
          cnt_d       = c_CNT_INIT;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          fail_a_d    = '0;
          fail_b_d    = '0;
          fail_mask_d = '0;
        end
      end

      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_CW'(1);
        end else begin
          if (w_mask != '0) begin
            // A zero count means no earlier failure in this sweep.
            if (err_q == '0) begin
              fail_a_d    = w_a;
              fail_b_d    = w_b;
              fail_mask_d = w_mask;
            end
            if (err_q != c_ERR_MAX) begin
              err_d = err_q + ERRW'(1);
            end
          end
          if (v_q == c_V_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == '0) && (w_mask == '0);
          end else begin
            v_d   = v_q + c_VW'(1);
            cnt_d = c_CNT_INIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      v_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign A         = w_a;
  assign B         = w_b;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_A    = fail_a_q;
  assign fail_B    = fail_b_q;
  assign fail_mask = fail_mask_q;

endmodule

`default_nettype wire
